// File: rtl/decode_issue_stage.sv
// ----------------------------------------------------------------------------
// decode_issue_stage
//   RV32I decode / issue stage sitting directly in front of the register file.
//   Decodes the fetched word, drives the register file read addresses, tracks
//   in-flight destination registers in a scoreboard, stalls on RAW/WAW hazards
//   and captures operands, immediate and control fields into a one-entry ID/EX
//   register with valid/ready handshakes on both sides.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch handshake (in_ready is combinational)
//   in_instr, in_pc          instruction word and its PC
//   rf_rs1_addr/rf_rs2_addr  register file read addresses (comb from in_instr)
//   rf_rs1_data/rf_rs2_data  register file read data
//   wb_valid, wb_rd          writeback retirement, clears scoreboard bit
//   flush                    kill held ID/EX entry, refuse input this cycle
//   out_valid/out_ready      execute handshake
//   out_*                    registered ID/EX fields
// ----------------------------------------------------------------------------
module decode_issue_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_reg_write,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]       opcode;
  logic [4:0]       rd_field;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             sign;

  logic             is_legal;
  logic             rs1_used;
  logic             rs2_used;
  logic             writes_rd;
  logic             reg_write;
  logic [31:0]      imm;

  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] pending;
  logic             stall;
  logic             accept;

  assign opcode      = in_instr[6:0];
  assign rd_field    = in_instr[11:7];
  assign rs1         = in_instr[19:15];
  assign rs2         = in_instr[24:20];
  assign sign        = in_instr[31];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // NOTE: every signal written in an always_comb block gets a default at the
  // top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    is_legal  = 1'b1;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    writes_rd = 1'b1;
    imm       = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        rs1_used = 1'b0;
        imm      = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        rs1_used = 1'b0;
        imm      = {{12{sign}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
        imm = {{20{sign}}, in_instr[31:20]};
      end
      OP_BRANCH: begin
        rs2_used  = 1'b1;
        writes_rd = 1'b0;
        imm       = {{20{sign}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_STORE: begin
        rs2_used  = 1'b1;
        writes_rd = 1'b0;
        imm       = {{20{sign}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_OP: begin
        rs2_used = 1'b1;
      end
      default: begin
        is_legal  = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  assign reg_write = writes_rd && (rd_field != 5'd0);

  // A register retiring this cycle is already readable (the register file
  // writes on the falling edge), so it is masked out of the pending set.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;
  end

  assign pending = sb & ~wb_mask & ~NREGS'(1);

  assign stall = flush
              || (rs1_used  && pending[rs1])
              || (rs2_used  && pending[rs2])
              || (reg_write && pending[rd_field])
              || (out_valid && !out_ready);

  assign in_ready = !rst && !stall;
  assign accept   = in_valid && in_ready;

  // Clears are applied first so a set on the same index wins.
  always_comb begin
    sb_next = sb & ~wb_mask;
    if (flush && out_valid && out_reg_write) sb_next[out_rd] = 1'b0;
    if (accept && reg_write)                 sb_next[rd_field] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb            <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else begin
      sb <= sb_next;
      if (accept) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_rs1_val   <= rf_rs1_data;
        out_rs2_val   <= rf_rs2_data;
        out_imm       <= imm;
        out_rd        <= reg_write ? rd_field : 5'd0;
        out_opcode    <= opcode;
        out_funct3    <= in_instr[14:12];
        out_funct7    <= in_instr[31:25];
        out_reg_write <= reg_write;
        out_illegal   <= !is_legal;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
